// File: rtl/parity_arbiter.sv
// parity_arbiter
//   Round-robin arbiter in front of one time-shared, bit-serial parity engine.
//   A requester's word is accepted in IDLE, its parity is accumulated one bit
//   per cycle in CALC, and {word, parity} is presented with the requester ID in
//   OUT until the downstream accepts it.
//
// Build option:
//   PARITY_ARB_ODD_EN  defined   -> odd parity (total ones in out_data is odd)
//                      undefined -> even parity (default)
//
// Ports:
//   clk        rising-edge clock
//   n_rst      asynchronous active-low reset
//   req_valid  [N_REQ]      per-requester word valid
//   req_data   [N_REQ*DW]   packed words, requester i at [i*DW +: DW]
//   req_ready  [N_REQ]      one-hot accept strobe (combinational from req_valid)
//   out_valid               out_data/out_id valid
//   out_ready               downstream accepts
//   out_data   [DW+1]       {word, parity}, parity in bit 0
//   out_id     [clog2(N_REQ)] requester that supplied the word
//   busy                    high whenever the FSM is not in IDLE
//   fsm_state  [2]          debug view of the FSM state (0 IDLE, 1 CALC, 2 OUT)
//
// Handshake: on both ports a transfer happens on the rising edge where valid
// and ready are both high. Requesters hold valid and data until their ready
// bit is seen; the output port holds out_data/out_id stable while out_valid
// is high and out_ready is low.

module parity_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 5
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW:0]                out_data,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic                       busy,
  output logic [1:0]                 fsm_state
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

`ifdef PARITY_ARB_ODD_EN
  localparam logic PAR_FLIP = 1'b1;
`else
  localparam logic PAR_FLIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   id;
  logic [DW-1:0]   shift;
  logic [DW-1:0]   word;
  logic            acc;
  logic [CW-1:0]   cnt;

  logic [IW-1:0]   winner;
  logic            found;
  logic            any_valid;
  logic [DW-1:0]   sel_word;
  int              idx;

  assign any_valid = |req_valid;
  assign fsm_state = state;

  // Round-robin search: first asserted index above last_grant, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign sel_word = req_data[int'(winner)*DW +: DW];

  // Accept strobe is only offered in IDLE; held low while reset is asserted
  // so every output reads zero during reset.
  always_comb begin
    req_ready = '0;
    if (n_rst && state == S_IDLE && any_valid) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      last_grant <= IW'(N_REQ - 1);
      id         <= '0;
      shift      <= '0;
      word       <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            shift      <= sel_word;
            word       <= sel_word;
            last_grant <= winner;
            id         <= winner;
            acc        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= S_CALC;
          end
        end
        S_CALC: begin
          acc   <= acc ^ shift[0];
          shift <= shift >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            // Last bit is folded in here rather than waiting another cycle.
            out_data  <= {word, acc ^ shift[0] ^ PAR_FLIP};
            out_id    <= id;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter
//   Self-checking bench for parity_arbiter (N_REQ=4, DW=5). A transaction-level
//   reference model runs at the falling edge: it picks winners by the
//   round-robin rule, predicts {word, parity} from the bench's own copy of each
//   requester's data, and expects output DW+1 cycles after each accept.
//   Directed scenarios are followed by a randomized phase.

module tb_parity_arbiter;

  localparam int N  = 4;
  localparam int DW = 5;
  localparam int IW = 2;

`ifdef PARITY_ARB_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW:0]     out_data;
  logic [IW-1:0]   out_id;
  logic            busy;
  logic [1:0]      fsm_state;
  logic [DW-1:0]   dat [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[g*DW +: DW] = dat[g];
  end

  parity_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs === exp_v) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp_v, cyc);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DW:0] exp_q[$];
  int          id_q[$];
  int          m_last = N - 1;   // last granted requester
  int          m_cnt  = -1;      // cycles since accept, -1 when idle
  int          g_id[$];          // grants observed on req_ready
  int          g_cyc[$];
  int          n_out = 0;
  int          h_cyc = 0;
  int          id3_outs = 0;
  int          g3 = 0;
  logic [DW:0] last_data;
  int          last_id;
  logic [N-1:0] acc_mask = '0;
  bit          keep_valid = 1'b0;

  function automatic int ref_winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    int gi;
    acc_mask = '0;
    if (!n_rst) begin
      m_last = N - 1;
      m_cnt  = -1;
      exp_q.delete();
      id_q.delete();
    end else begin
      if (req_ready != '0) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
        g_id.push_back(gi);
        g_cyc.push_back(cyc);
        if (gi == 3) g3++;
        acc_mask = req_ready;
      end
      if (m_cnt < 0) begin
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
        w = ref_winner(req_valid, m_last);
        if (w >= 0) begin
          check("grant", req_ready, 32'(1) << w);
          exp_q.push_back({dat[w], (^dat[w]) ^ ODD});
          id_q.push_back(w);
          m_last = w;
          m_cnt  = 0;
        end else begin
          check("no_grant", req_ready, 0);
        end
      end else begin
        m_cnt++;
        check("busy", busy, 1);
        check("busy_req_ready", req_ready, 0);
        if (m_cnt <= DW) begin
          check("calc_out_valid", out_valid, 0);
        end else begin
          check("out_valid", out_valid, 1);
          check("out_data", out_data, exp_q[0]);
          check("out_id", out_id, id_q[0]);
          if (out_ready) begin
            last_data = out_data;
            last_id   = out_id;
            if (out_id == 2'd3) id3_outs++;
            n_out++;
            h_cyc = cyc;
            void'(exp_q.pop_front());
            void'(id_q.pop_front());
            m_cnt = -1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid = req_valid & ~acc_mask;
  endtask

  task automatic wait_out(input int target, input int budget);
    int k = 0;
    while (n_out < target && k < budget) begin
      tick();
      k++;
    end
    check("wait_out", n_out, target);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_cnt >= 0 || req_valid != '0) && k < budget) begin
      tick();
      k++;
    end
    check("wait_idle", (m_cnt < 0) && (req_valid == '0), 1);
  endtask

  task automatic wait_grant(input int sz, input int budget);
    int k = 0;
    while (g_id.size() <= sz && k < budget) begin
      tick();
      k++;
    end
    check("wait_grant", g_id.size() > sz, 1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, n0, gsz, g3_0, id3_0, k;
    n_rst = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_busy", busy, 0);
    check("rst_state", fsm_state, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // All requesters valid: order 0,1,2,3,0, accepts 7 cycles apart
    for (int i = 0; i < N; i++) dat[i] = DW'($urandom_range(0, 31));
    keep_valid = 1'b1;
    out_ready  = 1'b1;
    base = g_id.size();
    req_valid = '1;
    k = 0;
    while (g_id.size() < base + 5 && k < 60) begin
      tick();
      k++;
    end
    check("rr_count", g_id.size() >= base + 5, 1);
    if (g_id.size() >= base + 5) begin
      for (int j = 0; j < 5; j++) check("rr_order", g_id[base + j], j % N);
      for (int j = 1; j < 5; j++) check("rr_gap", g_cyc[base + j] - g_cyc[base + j - 1], DW + 2);
    end
    keep_valid = 1'b0;
    req_valid  = '0;
    wait_idle(30);

    // Single request, parity 1
    dat[2] = 5'b10110;
    n0 = n_out;
    req_valid = 4'b0100;
    wait_out(n0 + 1, 20);
    check("p1_data", last_data, {5'b10110, 1'b1 ^ ODD});
    check("p1_id", last_id, 2);
    check("p1_latency", h_cyc - g_cyc[$], DW + 1);
    wait_idle(10);

    // Single request, parity 0
    dat[1] = 5'b00000;
    n0 = n_out;
    req_valid = 4'b0010;
    wait_out(n0 + 1, 20);
    check("p0_data", last_data, {5'b00000, ODD});
    check("p0_id", last_id, 1);
    wait_idle(10);

    // Backpressure with pending requests
    out_ready = 1'b0;
    dat[0] = DW'($urandom_range(0, 31));
    dat[1] = DW'($urandom_range(0, 31));
    dat[3] = DW'($urandom_range(0, 31));
    n0 = n_out;
    req_valid = 4'b0001;
    k = 0;
    while (m_cnt <= DW && k < 20) begin
      tick();
      k++;
    end
    check("bp_reach_out", out_valid, 1);
    req_valid = req_valid | 4'b1010;
    repeat (10) tick();
    gsz = g_id.size();
    out_ready = 1'b1;
    wait_out(n0 + 1, 5);
    wait_grant(gsz, 5);
    if (g_id.size() > gsz) begin
      check("bp_next_id", g_id[gsz], 1);
      check("bp_next_gap", g_cyc[gsz] - h_cyc, 1);
    end
    wait_idle(40);

    // Withdrawn request from requester 3 while busy
    g3_0  = g3;
    id3_0 = id3_outs;
    dat[0] = DW'($urandom_range(0, 31));
    n0 = n_out;
    req_valid = 4'b0001;
    tick();
    tick();
    req_valid[3] = 1'b1;
    tick();
    tick();
    req_valid[3] = 1'b0;
    wait_out(n0 + 1, 20);
    wait_idle(10);
    check("wd_grants3", g3, g3_0);
    check("wd_outs3", id3_outs, id3_0);

    // Reset mid-CALC
    dat[0] = DW'($urandom_range(0, 31));
    dat[1] = DW'($urandom_range(0, 31));
    req_valid = 4'b0010;
    tick();
    req_valid[1] = 1'b1;
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_id", out_id, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", fsm_state, 0);
    req_valid = 4'b0011;
    tick();
    n_rst = 1'b1;
    gsz = g_id.size();
    wait_grant(gsz, 5);
    if (g_id.size() > gsz) check("post_rst_first", g_id[gsz], 0);
    wait_idle(40);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          dat[i] = DW'($urandom_range(0, 31));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    req_valid = '0;
    out_ready = 1'b1;
    wait_idle(40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
